// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the host-to-board command parser.
//   - ASCII characters that carry meaning in the command grammar
//   - error cause codes reported on err_code
//   - parser state encoding
//   - line-terminator helper
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    // Command grammar characters
    localparam logic [7:0] CH_W  = 8'h57;   // 'W' : register write
    localparam logic [7:0] CH_R  = 8'h52;   // 'R' : register read
    localparam logic [7:0] CH_CR = 8'h0D;   // carriage return
    localparam logic [7:0] CH_LF = 8'h0A;   // line feed

    // Error causes reported on err_code
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] BAD_CMD  = 3'd1;  // unknown command letter
    localparam logic [2:0] BAD_HEX  = 3'd2;  // non-hex byte where a digit belongs
    localparam logic [2:0] SHORT    = 3'd3;  // terminator before all digits arrived
    localparam logic [2:0] LONG     = 3'd4;  // extra digit where terminator belongs
    localparam logic [2:0] TIMEOUT  = 3'd5;  // host went quiet mid-frame

    typedef enum logic [2:0] {
        IDLE,       // waiting for a command letter
        ADDR,       // waiting for the single address digit
        DATA,       // collecting write data digits, MSB first
        TERM,       // waiting for CR/LF to commit the frame
        DISCARD     // swallowing the rest of a bad line
    } parseState_t;

    // Either CR or LF ends a line, so CRLF and bare LF hosts both work.
    function automatic logic isLineEnd(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// -----------------------------------------------------------------------------
// hex_ascii_decode
// Combinational ASCII-hex digit decoder; inverse of the telemetry
// nibble-to-ASCII encoder. Accepts '0'-'9', 'A'-'F' and 'a'-'f'.
//
// Ports:
//   asciiByte  in   8  received character
//   isHex      out  1  character is a valid hex digit
//   nibble     out  4  digit value (0 when isHex is low)
// -----------------------------------------------------------------------------
module hex_ascii_decode (
    input  logic [7:0] asciiByte,
    output logic       isHex,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves an output unassigned in always_comb infers a latch.
        isHex  = 1'b0;
        nibble = 4'h0;
        if (asciiByte >= 8'h30 && asciiByte <= 8'h39) begin
            // '0'..'9' : low nibble of the code is the value
            isHex  = 1'b1;
            nibble = asciiByte[3:0];
        end else if ((asciiByte >= 8'h41 && asciiByte <= 8'h46) ||
                     (asciiByte >= 8'h61 && asciiByte <= 8'h66)) begin
            // 'A'..'F' / 'a'..'f' : low nibble is 1..6, value is 10..15
            isHex  = 1'b1;
            nibble = asciiByte[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Decodes ASCII-hex command lines from the UART receiver into register
// write strobes and read requests.
//   "W" A DDD <CR|LF>  -> write DATA_W-bit value to address A
//   "R" A <CR|LF>      -> read request for address A
// Bad lines raise a one-cycle err pulse with a held cause code; the rest of
// the line is then dropped silently up to the next terminator.
//
// Ports:
//   CLK_10MHZ  in   1       system clock
//   rst        in   1       synchronous active-high reset
//   rx_data    in   8       received byte
//   rx_valid   in   1       one-cycle pulse, rx_data valid
//   wr_en      out  1       one-cycle write strobe
//   wr_addr    out  ADDR_W  write address, held until next write
//   wr_data    out  DATA_W  write data, held until next write
//   rd_req     out  1       one-cycle read request
//   rd_addr    out  ADDR_W  read address, held until next read
//   err        out  1       one-cycle error pulse
//   err_code   out  3       last error cause, held until next error
//   frame_cnt  out  8       accepted commands, wraps
//   err_cnt    out  8       errors, saturates at 255
// -----------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W      = 4,       // one hex digit; must stay 4
    parameter int DATA_W      = 12,      // multiple of 4
    parameter int TIMEOUT_CYC = 100000   // max quiet cycles inside a frame
) (
    input  logic              CLK_10MHZ,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
);

    localparam int NUM_DIGITS = DATA_W / 4;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);
    localparam int TMR_W      = $clog2(TIMEOUT_CYC + 1);

    parseState_t       state, stateNext;
    logic              modeWr, modeWrNext;      // 1 = write frame, 0 = read frame
    logic [ADDR_W-1:0] addrSh, addrNext;
    logic [DATA_W-1:0] dataSh, dataNext;
    logic [CNT_W-1:0]  digitCnt, digitNext;
    logic [TMR_W-1:0]  idleTmr;

    logic              byteIsHex;
    logic [3:0]        byteNibble;
    logic              byteIsEol;
    logic              tmrExpired;

    logic              doWrite, doRead, raiseErr;
    logic [2:0]        errCause;

    hex_ascii_decode u_hexDecode (
        .asciiByte (rx_data),
        .isHex     (byteIsHex),
        .nibble    (byteNibble)
    );

    assign byteIsEol  = isLineEnd(rx_data);
    // The timer only runs outside IDLE, so expiry is meaningless there.
    assign tmrExpired = (state != IDLE) && (idleTmr == TMR_W'(TIMEOUT_CYC - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_10MHZ) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // -------------------------------------------------------------------------
    // Next-state and per-byte decisions
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext  = state;
        modeWrNext = modeWr;
        addrNext   = addrSh;
        dataNext   = dataSh;
        digitNext  = digitCnt;
        doWrite    = 1'b0;
        doRead     = 1'b0;
        raiseErr   = 1'b0;
        errCause   = ERR_NONE;

        if (rx_valid) begin
            // A byte arriving on the expiry cycle takes precedence over timeout.
            case (state)
                IDLE: begin
                    if (rx_data == CH_W) begin
                        stateNext  = ADDR;
                        modeWrNext = 1'b1;
                    end else if (rx_data == CH_R) begin
                        stateNext  = ADDR;
                        modeWrNext = 1'b0;
                    end else if (!byteIsEol) begin
                        // Bare CR/LF here is the tail of a CRLF pair; ignore it.
                        raiseErr  = 1'b1;
                        errCause  = BAD_CMD;
                        stateNext = DISCARD;
                    end
                end

                ADDR: begin
                    if (byteIsHex) begin
                        addrNext = ADDR_W'(byteNibble);
                        if (modeWr) begin
                            stateNext = DATA;
                            digitNext = '0;
                        end else begin
                            stateNext = TERM;
                        end
                    end else if (byteIsEol) begin
                        raiseErr  = 1'b1;
                        errCause  = SHORT;
                        stateNext = IDLE;
                    end else begin
                        raiseErr  = 1'b1;
                        errCause  = BAD_HEX;
                        stateNext = DISCARD;
                    end
                end

                DATA: begin
                    if (byteIsHex) begin
                        // Exactly NUM_DIGITS shifts per frame, so any stale
                        // content from an earlier frame is pushed out fully.
                        dataNext  = (dataSh << 4) | DATA_W'(byteNibble);
                        digitNext = digitCnt + CNT_W'(1);
                        if (digitCnt == CNT_W'(NUM_DIGITS - 1))
                            stateNext = TERM;
                    end else if (byteIsEol) begin
                        raiseErr  = 1'b1;
                        errCause  = SHORT;
                        stateNext = IDLE;
                    end else begin
                        raiseErr  = 1'b1;
                        errCause  = BAD_HEX;
                        stateNext = DISCARD;
                    end
                end

                TERM: begin
                    if (byteIsEol) begin
                        doWrite   = modeWr;
                        doRead    = !modeWr;
                        stateNext = IDLE;
                    end else if (byteIsHex) begin
                        raiseErr  = 1'b1;
                        errCause  = LONG;
                        stateNext = DISCARD;
                    end else begin
                        raiseErr  = 1'b1;
                        errCause  = BAD_HEX;
                        stateNext = DISCARD;
                    end
                end

                DISCARD: begin
                    // Only one error per bad line; just wait for its end.
                    if (byteIsEol) stateNext = IDLE;
                end

                default: stateNext = IDLE;
            endcase
        end else if (tmrExpired) begin
            stateNext = IDLE;
            // An already-reported bad line times out quietly.
            if (state != DISCARD) begin
                raiseErr = 1'b1;
                errCause = TIMEOUT;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame accumulators, idle timer and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            modeWr    <= 1'b0;
            addrSh    <= '0;
            dataSh    <= '0;
            digitCnt  <= '0;
            idleTmr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            modeWr   <= modeWrNext;
            addrSh   <= addrNext;
            dataSh   <= dataNext;
            digitCnt <= digitNext;

            if (rx_valid || state == IDLE || tmrExpired)
                idleTmr <= '0;
            else
                idleTmr <= idleTmr + TMR_W'(1);

            wr_en  <= doWrite;
            rd_req <= doRead;
            err    <= raiseErr;

            if (doWrite) begin
                wr_addr <= addrSh;
                wr_data <= dataSh;
            end
            if (doRead)
                rd_addr <= addrSh;
            if (doWrite || doRead)
                frame_cnt <= frame_cnt + 8'd1;

            if (raiseErr) begin
                err_code <= errCause;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Bench for uart_cmd_parser. A line-buffer model (bytes collected per line,
// position decides what is legal) predicts every output each cycle; directed
// command lines plus literal expectations pin the model. The hex decoder is
// also swept over all 256 byte values.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int T  = 50;   // short timeout keeps the bench quick
    localparam int DW = 12;
    localparam int ND = DW / 4;

    logic          CLK_10MHZ;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [3:0]    rd_addr;
    logic          err;
    logic [2:0]    err_code;
    logic [7:0]    frame_cnt;
    logic [7:0]    err_cnt;

    // Stand-alone decoder for the exhaustive sweep
    logic [7:0]    hexIn;
    logic          hexOk;
    logic [3:0]    hexVal;

    int testsRun  = 0;
    int testsFail = 0;
    bit checkEn   = 0;

    uart_cmd_parser #(.ADDR_W(4), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .CLK_10MHZ (CLK_10MHZ),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .err       (err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    hex_ascii_decode u_hex (
        .asciiByte (hexIn),
        .isHex     (hexOk),
        .nibble    (hexVal)
    );

    initial begin
        CLK_10MHZ = 1'b0;
        forever #5 CLK_10MHZ = ~CLK_10MHZ;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic void hexLookup(input logic [7:0] b, output bit ok, output int v);
        string      digits;
        logic [7:0] u;
        digits = "0123456789ABCDEF";
        u  = (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;   // fold lowercase
        ok = 0;
        v  = 0;
        for (int k = 0; k < 16; k++)
            if (digits[k] == u) begin ok = 1; v = k; end
    endfunction

    logic [7:0]    lineBuf[$];     // bytes of the current line so far
    bit            discarding;
    int            cyc, lastByteCyc;
    logic          eWrEn, eRdReq, eErr;
    logic [3:0]    eWrAddr, eRdAddr;
    logic [DW-1:0] eWrData;
    logic [2:0]    eErrCode;
    int            eFrameCnt, eErrCnt;

    function automatic void mRaise(input int code);
        eErr     = 1'b1;
        eErrCode = 3'(code);
        if (eErrCnt < 255) eErrCnt++;
    endfunction

    function automatic void mCommit();
        bit ok;
        int a, d, v;
        hexLookup(lineBuf[1], ok, a);
        if (lineBuf[0] == "W") begin
            d = 0;
            for (int k = 2; k < 2 + ND; k++) begin
                hexLookup(lineBuf[k], ok, v);
                d = d * 16 + v;
            end
            eWrEn   = 1'b1;
            eWrAddr = 4'(a);
            eWrData = DW'(d);
        end else begin
            eRdReq  = 1'b1;
            eRdAddr = 4'(a);
        end
        eFrameCnt = (eFrameCnt + 1) % 256;
    endfunction

    function automatic void mByte(input logic [7:0] b);
        bit isT, isH;
        int v, need, n;
        isT = (b == 8'h0D) || (b == 8'h0A);
        hexLookup(b, isH, v);
        if (discarding) begin
            if (isT) discarding = 0;
            return;
        end
        n = lineBuf.size();
        if (n == 0) begin
            if (b == "W" || b == "R") lineBuf.push_back(b);
            else if (!isT) begin mRaise(1); discarding = 1; end
            return;
        end
        // Characters required before the terminator: letter, address, data.
        need = (lineBuf[0] == "W") ? 2 + ND : 2;
        if (n < need) begin
            if (isH)      lineBuf.push_back(b);
            else if (isT) begin mRaise(3); lineBuf.delete(); end
            else          begin mRaise(2); lineBuf.delete(); discarding = 1; end
        end else begin
            if (isT)      begin mCommit(); lineBuf.delete(); end
            else if (isH) begin mRaise(4); lineBuf.delete(); discarding = 1; end
            else          begin mRaise(2); lineBuf.delete(); discarding = 1; end
        end
    endfunction

    always @(posedge CLK_10MHZ) begin
        cyc++;
        eWrEn  = 1'b0;
        eRdReq = 1'b0;
        eErr   = 1'b0;
        if (rst) begin
            lineBuf.delete();
            discarding = 0;
            eWrAddr = '0; eWrData = '0; eRdAddr = '0; eErrCode = '0;
            eFrameCnt = 0; eErrCnt = 0;
        end else if (rx_valid) begin
            lastByteCyc = cyc;
            mByte(rx_data);
        end else if ((discarding || lineBuf.size() > 0) && (cyc - lastByteCyc == T)) begin
            // Host silent for T cycles inside a line
            if (!discarding) mRaise(5);
            lineBuf.delete();
            discarding = 0;
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare and pulse counters
    // -------------------------------------------------------------------------
    int wrPulses = 0, rdPulses = 0, errPulses = 0;

    always @(negedge CLK_10MHZ) begin
        if (checkEn) begin
            check("wr_en",     32'(wr_en),     32'(eWrEn));
            check("rd_req",    32'(rd_req),    32'(eRdReq));
            check("err",       32'(err),       32'(eErr));
            check("wr_addr",   32'(wr_addr),   32'(eWrAddr));
            check("wr_data",   32'(wr_data),   32'(eWrData));
            check("rd_addr",   32'(rd_addr),   32'(eRdAddr));
            check("err_code",  32'(err_code),  32'(eErrCode));
            check("frame_cnt", 32'(frame_cnt), 32'(eFrameCnt));
            check("err_cnt",   32'(err_cnt),   32'(eErrCnt));
            if (wr_en  === 1'b1) wrPulses++;
            if (rd_req === 1'b1) rdPulses++;
            if (err    === 1'b1) errPulses++;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus (tasks start and end 1 time unit after a rising edge)
    // -------------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK_10MHZ); #1; end
    endtask

    task automatic sendStr(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            idle(1);
            rx_valid = 1'b0;
            idle(gap);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    int w0, r0, e0;

    task automatic mark();
        w0 = wrPulses; r0 = rdPulses; e0 = errPulses;
    endtask

    initial begin
        bit ok;
        int v;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        hexIn    = 8'h00;
        lastByteCyc = 0;
        idle(1);
        checkEn = 1;
        rst = 1'b0;

        // Reset state
        check("reset err_code",  32'(err_code),  32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset wr_data",   32'(wr_data),   32'd0);

        // Decoder sweep over every byte value
        for (int b = 0; b < 256; b++) begin
            hexIn = 8'(b);
            #1;
            hexLookup(hexIn, ok, v);
            check("hex is_hex", 32'(hexOk), 32'(ok));
            if (ok) check("hex nibble", 32'(hexVal), 32'(v));
        end
        hexIn = "a"; #1; check("hex 'a'", {27'd0, hexOk, hexVal}, 32'h1A);
        hexIn = "F"; #1; check("hex 'F'", {27'd0, hexOk, hexVal}, 32'h1F);
        hexIn = "9"; #1; check("hex '9'", {27'd0, hexOk, hexVal}, 32'h19);
        hexIn = "g"; #1; check("hex 'g'", 32'(hexOk), 32'd0);
        hexIn = ":"; #1; check("hex ':'", 32'(hexOk), 32'd0);
        hexIn = "@"; #1; check("hex '@'", 32'(hexOk), 32'd0);
        // Realign to posedge+1
        @(posedge CLK_10MHZ); #1;

        // 1: basic write, bytes back to back
        doReset(); mark();
        sendStr("W5A3F\015", 0); idle(3);
        check("t1 wr pulses", 32'(wrPulses - w0), 32'd1);
        check("t1 err pulses", 32'(errPulses - e0), 32'd0);
        check("t1 wr_addr", 32'(wr_addr), 32'h5);
        check("t1 wr_data", 32'(wr_data), 32'hA3F);
        check("t1 frame_cnt", 32'(frame_cnt), 32'd1);

        // 2: read with CRLF
        doReset(); mark();
        sendStr("R2\015\012", 1); idle(3);
        check("t2 rd pulses", 32'(rdPulses - r0), 32'd1);
        check("t2 err pulses", 32'(errPulses - e0), 32'd0);
        check("t2 rd_addr", 32'(rd_addr), 32'h2);
        check("t2 frame_cnt", 32'(frame_cnt), 32'd1);

        // 3: short then long write
        doReset(); mark();
        sendStr("W1AB\015", 0); idle(2);
        check("t3 short code", 32'(err_code), 32'd3);
        check("t3 short err_cnt", 32'(err_cnt), 32'd1);
        sendStr("W5A3F7\015", 0); idle(2);
        check("t3 long code", 32'(err_code), 32'd4);
        check("t3 err_cnt", 32'(err_cnt), 32'd2);
        check("t3 wr pulses", 32'(wrPulses - w0), 32'd0);

        // 4: bad command, discarded line, then lowercase write
        doReset(); mark();
        sendStr("X12\015W0fff\015", 0); idle(3);
        check("t4 err pulses", 32'(errPulses - e0), 32'd1);
        check("t4 err_code", 32'(err_code), 32'd1);
        check("t4 wr pulses", 32'(wrPulses - w0), 32'd1);
        check("t4 wr_addr", 32'(wr_addr), 32'h0);
        check("t4 wr_data", 32'(wr_data), 32'hFFF);

        // 5a: byte arriving exactly at expiry wins over timeout
        doReset(); mark();
        sendStr("W3", 0); idle(T - 1);
        sendStr("001\015", 0); idle(3);
        check("t5a err pulses", 32'(errPulses - e0), 32'd0);
        check("t5a wr_data", 32'(wr_data), 32'h001);

        // 5b: timeout fires after exactly T quiet cycles, once
        doReset(); mark();
        sendStr("W3", 0); idle(T - 1);
        check("t5b early err", 32'(errPulses - e0), 32'd0);
        idle(2);
        check("t5b timeout err", 32'(errPulses - e0), 32'd1);
        check("t5b err_code", 32'(err_code), 32'd5);
        idle(T + 5);
        check("t5b single timeout", 32'(errPulses - e0), 32'd1);
        sendStr("W3001\015", 1); idle(3);
        check("t5b wr_data", 32'(wr_data), 32'h001);
        check("t5b wr_addr", 32'(wr_addr), 32'h3);

        // 5c: DISCARD times out silently back to IDLE
        doReset(); mark();
        sendStr("Q", 0); idle(T + 5);
        sendStr("R4\015", 0); idle(3);
        check("t5c err pulses", 32'(errPulses - e0), 32'd1);
        check("t5c rd pulses", 32'(rdPulses - r0), 32'd1);
        check("t5c rd_addr", 32'(rd_addr), 32'h4);

        // 6: reset mid-frame drops the partial line
        doReset(); mark();
        sendStr("W7A", 0);
        doReset();
        sendStr("BC\015", 0); idle(3);
        check("t6 wr pulses", 32'(wrPulses - w0), 32'd0);
        check("t6 err_code", 32'(err_code), 32'd1);
        check("t6 frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6 err_cnt", 32'(err_cnt), 32'd1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Host-to-board command decoder. It is the receive-side counterpart of the ASCII-hex telemetry stream the board transmits.
- Consumes bytes from async_receiver (RxD_data / RxD_data_ready).
- Parses ASCII-hex command lines.
- Emits single-cycle register write strobes and read requests to the control logic (encoder / bill-validator / sensor register file).
- Reports framing errors and timeouts.

Parameters:
ADDR_W, 4, address width; exactly 1 hex digit (fixed, must be 4)
DATA_W, 12, write data width; DATA_W/4 hex digits (must be multiple of 4)
TIMEOUT_CYC, 100000, max idle cycles between bytes inside a frame (10 ms @ 10 MHz)

Ports:
CLK_10MHZ  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  1-cycle pulse, rx_data valid
wr_en  out  1  1-cycle write strobe
wr_addr  out  ADDR_W  write address, held until next write
wr_data  out  DATA_W  write data, held until next write
rd_req  out  1  1-cycle read request
rd_addr  out  ADDR_W  read address, held until next read
err  out  1  1-cycle error pulse
err_code  out  3  last error cause, held until next error
frame_cnt  out  8  accepted commands, wraps 255->0
err_cnt  out  8  errors, saturates at 255

Behaviour:
- Frame grammar: 'W' A D..D T writes; 'R' A T reads.
  - A = 1 hex digit; D = exactly DATA_W/4 hex digits, MSB first.
  - T = CR (0x0D) or LF (0x0A).
  - Hex digits accept 0-9, A-F, a-f.
  - A bare CR/LF in IDLE is ignored, so CRLF line endings work.
- Reset: state IDLE; all outputs, counters and shift regs 0. Reset mid-frame discards the partial frame with no strobe.
- States and transitions (evaluated only on rx_valid, except timeout):
  - IDLE:
    - 'W' -> ADDR (mode write)
    - 'R' -> ADDR (mode read)
    - CR/LF -> stay
    - other -> err BAD_CMD(1), DISCARD
  - ADDR:
    - hex -> latch addr
      - write mode -> DATA, digit_cnt=0
      - read mode -> TERM
    - CR/LF -> err SHORT(3), IDLE
    - other -> err BAD_HEX(2), DISCARD
  - DATA:
    - hex -> data = {data[DATA_W-5:0], nibble}, digit_cnt++; after last digit -> TERM
    - CR/LF -> err SHORT(3), IDLE
    - other -> err BAD_HEX(2), DISCARD
  - TERM:
    - CR/LF -> commit, IDLE
    - hex digit -> err LONG(4), DISCARD
    - other -> err BAD_HEX(2), DISCARD
  - DISCARD:
    - CR/LF -> IDLE
    - all other bytes ignored, no further errors
- Commit timing: wr_en (with wr_addr / wr_data updated) or rd_req (with rd_addr updated) asserts exactly 1 cycle after the terminator's rx_valid cycle. frame_cnt increments in that same cycle.
- Error timing: err and err_code are updated 1 cycle after the offending byte. err_cnt increments in that same cycle, saturating.
- Idle timer:
  - Reset to 0 on every rx_valid; counts only while state is not IDLE.
  - Reaching TIMEOUT_CYC-1 in ADDR/DATA/TERM -> err TIMEOUT(5), IDLE.
  - Reaching it in DISCARD -> IDLE silently.
  - rx_valid in the same cycle as expiry wins: the byte is processed and the timer is cleared.
- Back-to-back rx_valid on consecutive cycles is fully supported; no backpressure exists.
- wr_en, rd_req and err are mutually exclusive per cycle by construction.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - ASCII constants: CH_W, CH_R, CH_CR, CH_LF.
  - Error code localparams: ERR_NONE=0, BAD_CMD=1, BAD_HEX=2, SHORT=3, LONG=4, TIMEOUT=5.
  - State encoding.
- One sub-module, hex_ascii_decode: combinational, byte in -> {is_hex, nibble[3:0]}. It is the inverse of the telemetry nibble-to-ASCII encoder. Unit-test it exhaustively over 0x00-0xFF.

Test Plan:
1. Send "W5A3F\r" -> one wr_en pulse one cycle after the '\r' valid; wr_addr=5, wr_data=0xA3F, frame_cnt=1, err never asserted.
2. Send "R2\r\n" -> one rd_req with rd_addr=2; the trailing LF is ignored; no err; frame_cnt=1.
3. Send "W1AB\r" -> err with err_code=3 (SHORT), no wr_en, err_cnt=1. Send "W5A3F7\r" -> err_code=4 (LONG), no wr_en.
4. Send "X12\rW0fff\r" -> err_code=1 (BAD_CMD) once, the rest of the line is discarded, then wr_en with wr_addr=0, wr_data=0xFFF (lowercase accepted).
5. With TIMEOUT_CYC=50, send "W3", then stall 50 cycles -> err_code=5 (TIMEOUT) exactly once. Then "W3001\r" -> wr_data=0x001.
6. Send "W7A", assert rst 1 cycle, then send "BC\r" -> no wr_en. After reset, 'B' gives err_code=1, the CR returns the parser to IDLE, frame_cnt=0, err_cnt=1. Also drive all bytes with rx_valid held every cycle to verify there are no dropped bytes.
